// File: rtl/ascon_pkg.sv
// Shared Ascon-128 definitions: IV, widths, round constants and the core FSM encoding.
`default_nettype none
package ascon_pkg;

    localparam int RATE_W  = 64;
    localparam int CAP_W   = 256;
    localparam int STATE_W = RATE_W + CAP_W;

    localparam logic [63:0] IV  = 64'h80400c0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD_ABS,
        ST_AD_PERM,
        ST_AD_PAD,
        ST_DOM_SEP,
        ST_MSG_ABS,
        ST_MSG_PERM,
        ST_FINAL,
        ST_DONE
    } state_t;

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return 8'hf0 - 8'(idx) * 8'h0f;
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_aead_core_round.sv
// One Ascon round: constant addition, 5-bit S-box layer (bitsliced) and linear diffusion.
`default_nettype none
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [7:0]         rc_i,
    output logic [STATE_W-1:0] state_o
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    assign a0 = state_i[319:256] ^ state_i[63:0];
    assign a1 = state_i[255:192];
    assign a2 = state_i[191:128] ^ {56'd0, rc_i} ^ state_i[255:192];
    assign a3 = state_i[127:64];
    assign a4 = state_i[63:0] ^ state_i[127:64];

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign state_o = {
        c0 ^ rotr64(c0, 19) ^ rotr64(c0, 28),
        c1 ^ rotr64(c1, 61) ^ rotr64(c1, 39),
        c2 ^ rotr64(c2, 1)  ^ rotr64(c2, 6),
        c3 ^ rotr64(c3, 10) ^ rotr64(c3, 17),
        c4 ^ rotr64(c4, 7)  ^ rotr64(c4, 41)
    };

endmodule
`default_nettype wire

// File: rtl/ascon_aead_core.sv
// Iterative streaming Ascon-128 AEAD engine, UNROLL rounds per cycle, valid/ready data ports.
`default_nettype none
module ascon_aead_core
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     nonce_i,
    input  logic [CNT_W-1:0] ad_blocks_i,
    input  logic [CNT_W-1:0] msg_blocks_i,
    input  logic [127:0]     tag_in_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_data_o,
    output logic [127:0]     tag_out_o,
    output logic             tag_ok_o,
    output logic             done_o
);

    localparam logic [3:0] RSTEP = 4'(UNROLL);

    state_t             fsm_q;
    logic [STATE_W-1:0] s_q;
    logic [127:0]       key_q, tag_in_q, tag_out_q;
    logic [CNT_W-1:0]   ad_cnt_q, msg_cnt_q;
    logic [3:0]         rnd_q;
    logic               mode_q, pad_q, busy_q, done_q, tag_ok_q, out_valid_q;
    logic [63:0]        out_data_q;

    logic [STATE_W-1:0] chain [UNROLL+1];
    logic [STATE_W-1:0] perm_out;
    logic               perm_last;
    logic [127:0]       tag_calc;

    assign chain[0] = s_q;
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        ascon_round u_round (
            .state_i (chain[j]),
            .rc_i    (round_const(rnd_q + 4'(j))),
            .state_o (chain[j+1])
        );
    end
    assign perm_out  = chain[UNROLL];
    assign perm_last = (int'(rnd_q) + UNROLL) == 12;
    assign tag_calc  = s_q[127:0] ^ key_q;

    // The message window stalls only on a full output register that is not draining.
    assign in_ready_o = (fsm_q == ST_AD_ABS) ||
                        ((fsm_q == ST_MSG_ABS) && (msg_cnt_q != '0) && (!out_valid_q || out_ready_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            s_q         <= '0;
            key_q       <= '0;
            tag_in_q    <= '0;
            tag_out_q   <= '0;
            ad_cnt_q    <= '0;
            msg_cnt_q   <= '0;
            rnd_q       <= '0;
            mode_q      <= 1'b0;
            pad_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (fsm_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        key_q     <= key_i;
                        tag_in_q  <= tag_in_i;
                        ad_cnt_q  <= ad_blocks_i;
                        msg_cnt_q <= msg_blocks_i;
                        s_q       <= {IV, key_i, nonce_i};
                        rnd_q     <= 4'd0;
                        pad_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        tag_ok_q  <= 1'b0;
                        tag_out_q <= '0;
                        fsm_q     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    s_q   <= perm_out;
                    rnd_q <= rnd_q + RSTEP;
                    if (perm_last) begin
                        s_q   <= perm_out ^ {192'd0, key_q};
                        fsm_q <= (ad_cnt_q != '0) ? ST_AD_ABS : ST_DOM_SEP;
                    end
                end
                ST_AD_ABS: begin
                    if (in_valid_i) begin
                        s_q[319:256] <= s_q[319:256] ^ in_data_i;
                        ad_cnt_q     <= ad_cnt_q - CNT_W'(1);
                        rnd_q        <= 4'd6;
                        fsm_q        <= ST_AD_PERM;
                    end
                end
                ST_AD_PERM: begin
                    s_q   <= perm_out;
                    rnd_q <= rnd_q + RSTEP;
                    if (perm_last) begin
                        if (ad_cnt_q != '0) begin
                            fsm_q <= ST_AD_ABS;
                        end else begin
                            fsm_q <= pad_q ? ST_DOM_SEP : ST_AD_PAD;
                        end
                    end
                end
                ST_AD_PAD: begin
                    s_q[319:256] <= s_q[319:256] ^ PAD;
                    pad_q        <= 1'b1;
                    rnd_q        <= 4'd6;
                    fsm_q        <= ST_AD_PERM;
                end
                ST_DOM_SEP: begin
                    s_q[0] <= ~s_q[0];
                    fsm_q  <= ST_MSG_ABS;
                end
                ST_MSG_ABS: begin
                    if (msg_cnt_q == '0) begin
                        // Implicit empty-block pad and finalization key mix share one cycle.
                        s_q   <= s_q ^ {PAD, key_q, 128'd0};
                        rnd_q <= 4'd0;
                        fsm_q <= ST_FINAL;
                    end else if (in_valid_i && in_ready_o) begin
                        out_data_q   <= s_q[319:256] ^ in_data_i;
                        out_valid_q  <= 1'b1;
                        s_q[319:256] <= mode_q ? in_data_i : (s_q[319:256] ^ in_data_i);
                        msg_cnt_q    <= msg_cnt_q - CNT_W'(1);
                        rnd_q        <= 4'd6;
                        fsm_q        <= ST_MSG_PERM;
                    end
                end
                ST_MSG_PERM: begin
                    s_q   <= perm_out;
                    rnd_q <= rnd_q + RSTEP;
                    if (perm_last) begin
                        fsm_q <= ST_MSG_ABS;
                    end
                end
                ST_FINAL: begin
                    s_q   <= perm_out;
                    rnd_q <= rnd_q + RSTEP;
                    if (perm_last) begin
                        fsm_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q || out_ready_i) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        tag_out_q <= tag_calc;
                        tag_ok_q  <= mode_q ? (tag_calc == tag_in_q) : 1'b1;
                        fsm_q     <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tag_out_o   = tag_out_q;
    assign tag_ok_o    = tag_ok_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
`default_nettype wire

// File: doc/ascon_aead_core.md
Name: ascon_aead_core

Overview:
- Iterative, streaming Ascon-128 AEAD engine: encrypt or decrypt, any number of 64-bit AD and message blocks.
- Follow-on to the single-block combinational `ascon_encrypt`/`top` pair. That pair handles one AD block and one plaintext block in one cycle.
- This block holds the 320-bit state in registers and applies UNROLL rounds per cycle. Data moves over valid/ready streams, so it sits behind a bus adapter or DMA.

Parameters:
- UNROLL, 1, rounds per cycle; legal values 1, 2, 3, 6 (divides 12 and 6).
- CNT_W, 16, width of the block-count inputs.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- MODE  in  1  0 = encrypt, 1 = decrypt; latched on START.
- KEY  in  128  secret key; latched on START.
- NONCE  in  128  nonce; latched on START.
- AD_BLOCKS  in  CNT_W  number of full 64-bit AD blocks (0 allowed); latched on START.
- MSG_BLOCKS  in  CNT_W  number of full 64-bit message blocks (0 allowed); latched on START.
- TAG_IN  in  128  expected tag for decrypt; latched on START.
- BUSY  out  1  high from the cycle after START until DONE.
- IN_VALID / IN_READY / IN_DATA  in/out/in  1/1/64  AD then message blocks, big-endian.
- OUT_VALID / OUT_READY / OUT_DATA  out/in/out  1/1/64  ciphertext (encrypt) or plaintext (decrypt).
- TAG_OUT  out  128  computed tag; valid while DONE=1.
- TAG_OK  out  1  decrypt: TAG_OUT==TAG_IN; encrypt: 1.
- DONE  out  1  one-cycle pulse at completion.

Behaviour:
- Reset: every output 0 (IN_READY, OUT_VALID, BUSY, DONE, TAG_OK, TAG_OUT, OUT_DATA); FSM returns to IDLE. Reset mid-operation aborts the operation and discards any pending output.
- INIT:
  - Set S = 0x80400c0600000000 || K || N.
  - Run 12 rounds, taking 12/UNROLL cycles.
  - Then S ^= 0^192 || K.
- AD_ABS (only if AD_BLOCKS>0):
  - IN_READY=1; on each handshake, S[319:256] ^= IN_DATA.
  - Run 6 rounds (6/UNROLL cycles) with IN_READY=0.
  - After the last AD block, absorb the internal pad block 0x8000000000000000, then 6 more rounds.
- DOM_SEP: S[0] ^= 1, always applied, in a single cycle.
- MSG (per block):
  - IN_READY = !OUT_VALID || OUT_READY.
  - Encrypt: C = S_r ^ IN_DATA; S_r = C.
  - Decrypt: P = S_r ^ IN_DATA; S_r = IN_DATA.
  - The result loads the output register; OUT_VALID is held until OUT_READY.
  - Run 6 rounds after every message block.
  - After the last block, apply the implicit pad S_r ^= 0x80 << 56. No output beat is produced for the pad.
- FINAL:
  - S ^= 0^64 || K || 0^128.
  - Run 12 rounds.
  - TAG = S[127:0] ^ K.
  - Wait until the last OUT beat has been accepted, then pulse DONE and present TAG_OUT/TAG_OK. Both hold until the next START.
- Round constants: round i (0..11) uses c = 0xf0 - i*0x0f. The p^6 permutation uses rounds 6..11.
- Edge cases:
  - START while BUSY is ignored.
  - MSG_BLOCKS=0 skips straight to the pad, then FINAL.
  - IN_VALID outside an absorb window is ignored.
  - TAG_OK is undefined-free: it is forced to 0 between START and DONE.
- Decrypt releases plaintext before the tag is verified; the consumer must gate on TAG_OK.

Decomposition:
- Package `ascon_pkg`:
  - IV constant.
  - Round-constant function.
  - Rate/capacity widths.
  - FSM state enum: IDLE, INIT, AD_ABS, AD_PERM, AD_PAD, DOM_SEP, MSG_ABS, MSG_PERM, FINAL, DONE.
- Sub-module `ascon_round`: combinational, inputs 320-bit state + 8-bit constant. Applies constant addition, S-box layer and linear layer. It is chained UNROLL times inside the core.

Test Plan:
- Encrypt, K=N=000102..0F, AD_BLOCKS=0, MSG_BLOCKS=0 -> DONE, TAG_OUT=E355159F292911F794CB1432A0103A8A, no OUT beats.
- Encrypt, AD_BLOCKS=1, MSG_BLOCKS=1, random K/N/A/P -> C and T bit-identical to the `ascon_encrypt` module given the same inputs. Repeat for UNROLL=1,2,3,6.
- Encrypt 4 AD + 8 msg blocks, then decrypt the output with TAG_IN = TAG_OUT -> recovered plaintext matches the original, TAG_OK=1.
- Same decrypt with TAG_IN bit 0 flipped -> identical plaintext beats, TAG_OK=0.
- Random OUT_READY backpressure (30% low) and IN_VALID gaps -> no lost or duplicated beats; C stream identical to the no-stall run.
- Assert RST_N low during MSG_PERM of block 3 -> all outputs 0 next edge, IDLE. A fresh START then reproduces the scenario-1 tag; START pulses during BUSY are ignored.
